// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_pkg
// Purpose : Shared button indices, repeat-FSM states and 25 MHz timing defaults.
// Revision: 1.0 - initial release
// ============================================================================
package button_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_R = 3;
    localparam int BTN_L = 4;

    // 0.8 ms debounce, 10 ms initial hold, 2 ms repeat period at 25 MHz
    localparam int c_DEF_NUM_BTNS        = 5;
    localparam int c_DEF_DEBOUNCE_CYCLES = 20000;
    localparam int c_DEF_REPEAT_DELAY    = 250000;
    localparam int c_DEF_REPEAT_RATE     = 50000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repeat_state_t;

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module  : button_channel
// Purpose : One button: 2-FF sync, counter debounce, edge pulses, hold-repeat.
// Revision: 1.0 - initial release
// ============================================================================
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = c_DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_action
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RPT_W  = $clog2(c_RPT_MAX + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RPT_W-1:0] c_DELAY_LAST = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_RATE_LAST  = c_RPT_W'(REPEAT_RATE - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic                r_level;
    logic                r_press;
    logic                r_release;
    logic                r_repeat;
    repeat_state_t       r_state;
    logic [c_RPT_W-1:0]  r_rpt_cnt;

    logic w_diff;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    assign w_diff = r_sync2 ^ r_level;
    assign w_flip = w_diff && (r_db_cnt == c_DB_LAST);
    assign w_rise = w_flip && !r_level;
    assign w_fall = w_flip && r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_press   <= w_rise;
            r_release <= w_fall;
            if (!w_diff || w_flip) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_flip) begin
                r_level <= !r_level;
            end
        end
    end

    // Repeat FSM keys off the debounce flip itself, so DELAY starts on the
    // same edge that raises btn_press and a falling edge kills any pending pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (!i_repeat_en || w_fall || (!r_level && !w_rise)) begin
                r_state   <= IDLE;
                r_rpt_cnt <= '0;
            end else if (w_rise) begin
                r_state   <= DELAY;
                r_rpt_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state   <= DELAY;
                        r_rpt_cnt <= '0;
                    end
                    DELAY: begin
                        if (r_rpt_cnt == c_DELAY_LAST) begin
                            r_repeat  <= 1'b1;
                            r_rpt_cnt <= '0;
                            r_state   <= REPEAT;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (r_rpt_cnt == c_RATE_LAST) begin
                            r_repeat  <= 1'b1;
                            r_rpt_cnt <= '0;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_rpt_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_action  = r_press | r_repeat;

endmodule : button_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : button_conditioner
// Purpose : NUM_BTNS independent button channels feeding chess_logic.
// Revision: 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTNS        = c_DEF_NUM_BTNS,
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = c_DEF_REPEAT_RATE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_in,
    input  logic [NUM_BTNS-1:0] repeat_en,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_action,
    output logic                any_action
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
            button_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE)
            ) u_chan (
                .clk         (clk),
                .rst_n       (reset),
                .i_btn       (btn_in[gi]),
                .i_repeat_en (repeat_en[gi]),
                .o_level     (btn_level[gi]),
                .o_press     (btn_press[gi]),
                .o_release   (btn_release[gi]),
                .o_action    (btn_action[gi])
            );
        end
    endgenerate

    assign any_action = |btn_action;

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_conditioner
// Purpose : Directed checks of debounce, edge pulses, auto-repeat and reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int N = 5;

    logic         clk;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] repeat_en;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_action;
    logic         any_action;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .NUM_BTNS        (N),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .repeat_en   (repeat_en),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_action  (btn_action),
        .any_action  (any_action)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] lvl, input logic [N-1:0] prs,
                             input logic [N-1:0] rel, input logic [N-1:0] act);
        check({tag, ".level"},   32'(btn_level),   32'(lvl));
        check({tag, ".press"},   32'(btn_press),   32'(prs));
        check({tag, ".release"}, 32'(btn_release), 32'(rel));
        check({tag, ".action"},  32'(btn_action),  32'(act));
        check({tag, ".any"},     32'(any_action),  32'(|act));
    endtask

    initial begin
        logic [N-1:0] exp_act;
        logic [N-1:0] exp_lvl;
        logic [N-1:0] exp_rel;

        reset     = 1'b0;
        btn_in    = '0;
        repeat_en = '0;
        #1;
        check_all("reset_t0", 5'b0, 5'b0, 5'b0, 5'b0);
        tick(3);
        check_all("reset_held", 5'b0, 5'b0, 5'b0, 5'b0);
        reset = 1'b1;
        tick(2);

        // Clean press and release on BTNU
        btn_in = 5'b00010;
        tick(5);
        check_all("press_early", 5'b0, 5'b0, 5'b0, 5'b0);
        tick(1);
        check_all("press_edge", 5'b00010, 5'b00010, 5'b0, 5'b00010);
        tick(1);
        check_all("press_after", 5'b00010, 5'b0, 5'b0, 5'b0);
        btn_in = 5'b0;
        tick(5);
        check_all("rel_early", 5'b00010, 5'b0, 5'b0, 5'b0);
        tick(1);
        check_all("rel_edge", 5'b0, 5'b0, 5'b00010, 5'b0);
        tick(1);
        check_all("rel_after", 5'b0, 5'b0, 5'b0, 5'b0);

        // Bounce on BTNC: 2-sample glitches must not pass
        for (int i = 0; i < 8; i++) begin
            btn_in[0] = ((i / 2) % 2 == 0);
            tick(1);
            check_all($sformatf("bounce%0d", i), 5'b0, 5'b0, 5'b0, 5'b0);
        end
        btn_in[0] = 1'b1;
        tick(5);
        check_all("bounce_hold_early", 5'b0, 5'b0, 5'b0, 5'b0);
        tick(1);
        check_all("bounce_press", 5'b00001, 5'b00001, 5'b0, 5'b00001);
        tick(1);
        check_all("bounce_once", 5'b00001, 5'b0, 5'b0, 5'b0);
        btn_in[0] = 1'b0;
        tick(6);
        check_all("bounce_rel", 5'b0, 5'b0, 5'b00001, 5'b0);
        tick(1);

        // Auto-repeat on BTNR; release lands on a would-be repeat slot
        repeat_en = 5'b01000;
        btn_in    = 5'b01000;
        tick(6);
        check_all("rpt_press", 5'b01000, 5'b01000, 5'b0, 5'b01000);
        for (int i = 1; i <= 45; i++) begin
            if (i == 32) btn_in[3] = 1'b0;
            tick(1);
            exp_act = (i >= 10 && (i - 10) % 3 == 0 && i < 37) ? 5'b01000 : 5'b0;
            exp_lvl = (i < 37) ? 5'b01000 : 5'b0;
            exp_rel = (i == 37) ? 5'b01000 : 5'b0;
            check_all($sformatf("rpt_p%0d", i), exp_lvl, 5'b0, exp_rel, exp_act);
        end
        repeat_en = '0;

        // Repeat enable dropped then re-raised on BTNL
        repeat_en = 5'b10000;
        btn_in    = 5'b10000;
        tick(6);
        check_all("dis_press", 5'b10000, 5'b10000, 5'b0, 5'b10000);
        for (int i = 1; i <= 34; i++) begin
            if (i == 12) repeat_en[4] = 1'b0;
            if (i == 20) repeat_en[4] = 1'b1;
            tick(1);
            exp_act = (i == 10 || i == 30 || i == 33) ? 5'b10000 : 5'b0;
            check_all($sformatf("dis_p%0d", i), 5'b10000, 5'b0, 5'b0, exp_act);
        end
        repeat_en = '0;
        btn_in    = '0;
        tick(6);
        check_all("dis_rel", 5'b0, 5'b0, 5'b10000, 5'b0);
        tick(2);

        // Simultaneous BTND + BTNL
        btn_in = 5'b10100;
        tick(5);
        check_all("sim_early", 5'b0, 5'b0, 5'b0, 5'b0);
        tick(1);
        check_all("sim_press", 5'b10100, 5'b10100, 5'b0, 5'b10100);
        tick(1);
        check_all("sim_after", 5'b10100, 5'b0, 5'b0, 5'b0);
        tick(3);

        // Asynchronous reset mid-hold, applied between clock edges
        #3;
        reset = 1'b0;
        #1;
        check_all("areset_now", 5'b0, 5'b0, 5'b0, 5'b0);
        tick(2);
        check_all("areset_held", 5'b0, 5'b0, 5'b0, 5'b0);
        reset = 1'b1;
        tick(5);
        check_all("post_rst_early", 5'b0, 5'b0, 5'b0, 5'b0);
        tick(1);
        check_all("post_rst_press", 5'b10100, 5'b10100, 5'b0, 5'b10100);
        tick(1);
        check_all("post_rst_after", 5'b10100, 5'b0, 5'b0, 5'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
